// File: rtl/spi_pkg.sv
// Shared SPI command controller definitions: FSM state encoding and header bit positions.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    localparam int HDR_WR_BIT  = 7;
    localparam int HDR_RSV_BIT = 6;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: header byte then burst of register words; reg_we/reg_re strobe 1 cycle after the completing byte.
// No backpressure: every byte_valid is consumed; read data must arrive exactly 1 cycle after reg_re.
module spi_cmd_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ssel_active,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_in,
    output logic [7:0]              tx_byte,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    output logic                    busy,
    output logic                    err_abort
);

    localparam int W     = 8 * DATA_BYTES;
    localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

    state_t           state, state_next;
    logic             ssel_q;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     tx_sh;
    logic             rd_pend;
    logic             bv;
    logic             cnt_last;
    logic             unused_hdr;

    assign bv         = byte_valid & ssel_active;
    assign cnt_last   = (cnt == CNT_LAST);
    assign busy       = (state != ST_IDLE);
    assign unused_hdr = ^byte_in;

    // The word arriving from the register file is forwarded straight through in its
    // landing cycle so the next byte is ready 2 cycles after the word's last byte_valid.
    always_comb begin
        tx_byte = 8'h00;
        if (state == ST_RD_DATA) begin
            tx_byte = rd_pend ? reg_rdata[W-1 -: 8] : tx_sh[W-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!ssel_active) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!ssel_q) state_next = ST_HDR;
                end
                ST_HDR: begin
                    if (bv) begin
                        if (byte_in[HDR_RSV_BIT])     state_next = ST_DISCARD;
                        else if (byte_in[HDR_WR_BIT]) state_next = ST_WR_DATA;
                        else                          state_next = ST_RD_DATA;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ssel_q    <= 1'b0;
            cnt       <= '0;
            tx_sh     <= '0;
            rd_pend   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            ssel_q    <= ssel_active;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err_abort <= 1'b0;
            rd_pend   <= reg_re;

            // Strobes use the current address; advance it right after each access.
            if (reg_we || reg_re) reg_addr <= reg_addr + ADDR_W'(1);
            if (rd_pend)          tx_sh    <= reg_rdata;

            if (!ssel_active) begin
                cnt <= '0;
                if ((state == ST_WR_DATA || state == ST_RD_DATA) && cnt != '0) begin
                    err_abort <= 1'b1;
                end
            end else begin
                case (state)
                    ST_HDR: begin
                        if (bv) begin
                            cnt   <= '0;
                            tx_sh <= '0;
                            if (!byte_in[HDR_RSV_BIT]) begin
                                reg_addr <= byte_in[ADDR_W-1:0];
                                reg_re   <= ~byte_in[HDR_WR_BIT];
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (bv) begin
                            reg_wdata <= (reg_wdata << 8) | W'(byte_in);
                            cnt       <= cnt_last ? '0 : cnt + CNT_W'(1);
                            reg_we    <= cnt_last;
                        end
                    end
                    ST_RD_DATA: begin
                        if (bv) begin
                            tx_sh  <= rd_pend ? (reg_rdata << 8) : (tx_sh << 8);
                            cnt    <= cnt_last ? '0 : cnt + CNT_W'(1);
                            reg_re <= cnt_last;
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, register address width.
REQ-002 Parameter DATA_BYTES, default 4, bytes per register word (word width 8*DATA_BYTES).
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 ssel_active  input  1  chip-select active, already synchronized to clk.
REQ-006 byte_valid  input  1  one-cycle strobe: a received byte is on byte_in.
REQ-007 byte_in  input  8  received SPI byte, MSB-first assembled.
REQ-008 tx_byte  output  8  next byte for the SPI slave's send_data.
REQ-009 reg_addr  output  ADDR_W  register address.
REQ-010 reg_wdata  output  8*DATA_BYTES  write data.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe.
REQ-013 reg_rdata  input  8*DATA_BYTES  read data, valid exactly 1 cycle after reg_re.
REQ-014 busy  output  1  high while a frame is open (state not IDLE).
REQ-015 err_abort  output  1  one-cycle pulse when a frame ends with a partial word.

Function
REQ-016 States SHALL be IDLE, HDR, WR_DATA, RD_DATA, DISCARD.
REQ-017 IDLE -> HDR when ssel_active rises; any state -> IDLE in the cycle after ssel_active is low.
REQ-018 Header byte in HDR: bit7=1 write, bit7=0 read; bit6 SHALL be 0, else -> DISCARD; bits[ADDR_W-1:0] load the address counter.
REQ-019 WR_DATA: bytes shift into reg_wdata MSB-first; byte counter counts 0..DATA_BYTES-1.
REQ-020 On the DATA_BYTES-th byte, reg_we SHALL pulse the next cycle with reg_addr equal to the current address; the address then increments, wrapping 2^ADDR_W-1 -> 0.
REQ-021 On read header, reg_re SHALL pulse the cycle after the header byte_valid; reg_rdata is captured into the tx shift register 1 cycle later.
REQ-022 RD_DATA: tx_byte SHALL present the captured word MSB byte first and advance one byte per byte_valid; tx_byte SHALL be updated at most 2 cycles after byte_valid.
REQ-023 After the last byte of a read word: address increments (wrapping), reg_re pulses again, burst continues.
REQ-024 In HDR, WR_DATA and DISCARD, tx_byte SHALL be 8'h00.
REQ-025 DISCARD ignores all bytes until ssel_active falls; no strobes issued.
REQ-026 ssel_active low with byte counter nonzero in WR_DATA or RD_DATA: err_abort pulses, no reg_we for the partial word.
REQ-027 byte_valid coincident with ssel_active low SHALL be ignored.
REQ-028 reg_we and reg_re SHALL never both be high in one cycle.

Reset
REQ-029 On resetn low: state IDLE; tx_byte, reg_addr, reg_wdata 0; reg_we, reg_re, busy, err_abort 0; counters 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no strobe and no err_abort.

Structure
REQ-031 State encoding and header bit positions (WR bit 7, reserved bit 6) SHALL reside in shared package spi_pkg.
REQ-032 Single module; no sub-modules.

Verification
REQ-033 Write: header 8'h83, bytes DE AD BE EF -> one reg_we, reg_addr 3, reg_wdata 32'hDEADBEEF.
REQ-034 Read burst: header 8'h0F, reg_rdata 32'h11223344 then 32'h55667788 -> tx_byte 11,22,33,44,55,66,77,88; reg_re at addr 15 then 0.
REQ-035 Abort: header 8'h82, bytes 01 02, ssel_active falls -> err_abort pulse, no reg_we, busy low next cycle.
REQ-036 Reserved: header 8'h40, 4 bytes -> no strobes, tx_byte 00 throughout.
REQ-037 Reset: assert resetn low after header 8'h81 plus 2 bytes -> all outputs 0, next frame 8'h81 + 4 bytes writes addr 1 correctly.
